pwm_bank: RTL and testbench

Eight-channel, 16-bit, phase-staggered PWM generator that consumes the per-channel duty values held in the top-level value registers, which are written by the SPI receiver.
- Each channel double-buffers its duty value and reloads it only at its own period boundary, so SPI writes never cause runt pulses.
- Outputs drive the channel enables; the top level inverts them.
- Channel phases are spread evenly across the period to limit simultaneous switching current.

---
 rtl/pwm_pkg.sv | 15 +
 rtl/pwm_channel.sv | 34 +++
 rtl/pwm_bank.sv | 95 +++++++++
 tb/tb_pwm_bank.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the eight-channel PWM bank.
// Phase offsets spread the channel edges evenly across one counter period.
package pwm_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int NUM_CH    = 8;

  // One eighth of the period per channel index when staggering, otherwise aligned.
  function automatic int unsigned phase_offset(input int unsigned i,
                                               input bit          stagger,
                                               input int unsigned width = DEF_WIDTH);
    return stagger ? (i << (width - 3)) : 32'd0;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: duty shadow register reloaded at the end of its own phase,
// comparator against the channel phase, and a registered output.
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             tick,
  input  logic [WIDTH-1:0] ph,
  input  logic [WIDTH-1:0] v,
  output logic             o
);

  localparam logic [WIDTH-1:0] PH_LAST = '1;

  logic [WIDTH-1:0] sh_reg;

  // The shadow loads on the tick that wraps the phase to 0, so a new duty
  // always starts on a fresh period and cannot produce a runt pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sh_reg <= '0;
      o      <= 1'b0;
    end else begin
      if (tick && (ph == PH_LAST)) begin
        sh_reg <= v;
      end
      o <= (ph < sh_reg);
    end
  end

endmodule

// File: rtl/pwm_bank.sv
// Eight-channel phase-staggered PWM generator: shared prescaler and base
// counter, per-channel phase adders, and one pwm_channel per output.
module pwm_bank
  import pwm_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int PRESCALE = 1,
  parameter int STAGGER  = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] v0,
  input  logic [WIDTH-1:0] v1,
  input  logic [WIDTH-1:0] v2,
  input  logic [WIDTH-1:0] v3,
  input  logic [WIDTH-1:0] v4,
  input  logic [WIDTH-1:0] v5,
  input  logic [WIDTH-1:0] v6,
  input  logic [WIDTH-1:0] v7,
  output logic             o0,
  output logic             o1,
  output logic             o2,
  output logic             o3,
  output logic             o4,
  output logic             o5,
  output logic             o6,
  output logic             o7,
  output logic             period_start
);

  localparam int               PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]    PCNT_LAST  = PW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] CNT_LAST   = '1;

  logic [PW-1:0]    pcnt_reg;
  logic [WIDTH-1:0] cnt_reg;
  logic             tick;
  logic [WIDTH-1:0] v_bus [NUM_CH];
  logic [WIDTH-1:0] ph    [NUM_CH];
  logic [NUM_CH-1:0] o_bus;

  assign v_bus[0] = v0;
  assign v_bus[1] = v1;
  assign v_bus[2] = v2;
  assign v_bus[3] = v3;
  assign v_bus[4] = v4;
  assign v_bus[5] = v5;
  assign v_bus[6] = v6;
  assign v_bus[7] = v7;

  assign o0 = o_bus[0];
  assign o1 = o_bus[1];
  assign o2 = o_bus[2];
  assign o3 = o_bus[3];
  assign o4 = o_bus[4];
  assign o5 = o_bus[5];
  assign o6 = o_bus[6];
  assign o7 = o_bus[7];

  // With PRESCALE=1 the prescaler is stuck at 0 and tick stays high.
  assign tick = (pcnt_reg == PCNT_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pcnt_reg     <= '0;
      cnt_reg      <= '0;
      period_start <= 1'b0;
    end else begin
      pcnt_reg     <= tick ? '0 : (pcnt_reg + 1'b1);
      if (tick) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
      period_start <= tick && (cnt_reg == CNT_LAST);
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    localparam logic [WIDTH-1:0] OFFS = WIDTH'(phase_offset(gi, STAGGER != 0, WIDTH));

    // Phase wraps naturally through the WIDTH-bit addition.
    assign ph[gi] = cnt_reg + OFFS;

    pwm_channel #(
      .WIDTH(WIDTH)
    ) u_ch (
      .clock(clock),
      .reset(reset),
      .tick (tick),
      .ph   (ph[gi]),
      .v    (v_bus[gi]),
      .o    (o_bus[gi])
    );
  end

endmodule

// File: tb/tb_pwm_bank.sv
// Bench for pwm_bank: three small instances (aligned, staggered, prescaled)
// checked every clock against a cycle-count based model, plus targeted scenarios.
module tb_pwm_bank;

  localparam int W    = 4;
  localparam int NDUT = 3;
  localparam int NTAB = 14;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [NDUT-1:0][7:0][W-1:0] v;
  logic [NDUT-1:0][7:0]        o;
  logic [NDUT-1:0]             ps;

  always #5 clock = ~clock;

  // dut 0: aligned, no prescale; dut 1: staggered; dut 2: staggered, PRESCALE=3
  function automatic int pre_of(input int d);
    return (d == 2) ? 3 : 1;
  endfunction

  function automatic int off_of(input int d);
    return (d == 0) ? 0 : 2;
  endfunction

  for (genvar gd = 0; gd < NDUT; gd++) begin : g_dut
    logic [7:0] ob;
    logic       psb;
    pwm_bank #(
      .WIDTH   (W),
      .PRESCALE((gd == 2) ? 3 : 1),
      .STAGGER ((gd == 0) ? 0 : 1)
    ) u_dut (
      .clock       (clock),
      .reset       (reset),
      .v0          (v[gd][0]),
      .v1          (v[gd][1]),
      .v2          (v[gd][2]),
      .v3          (v[gd][3]),
      .v4          (v[gd][4]),
      .v5          (v[gd][5]),
      .v6          (v[gd][6]),
      .v7          (v[gd][7]),
      .o0          (ob[0]),
      .o1          (ob[1]),
      .o2          (ob[2]),
      .o3          (ob[3]),
      .o4          (ob[4]),
      .o5          (ob[5]),
      .o6          (ob[6]),
      .o7          (ob[7]),
      .period_start(psb)
    );
    assign o[gd]  = ob;
    assign ps[gd] = psb;
  end

  int c;
  int m_sh [NDUT][8];
  int vectors;
  int miscompares;

  typedef struct {
    int d;
    int ch;
    int duty;
    int first_rise;
    int high;
  } vec_t;

  vec_t tab [NTAB];
  int first_rise [NDUT][8];
  int high_cnt   [NDUT][8];
  int ps_cnt     [NDUT];

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: after c clocks since reset release, cnt = (c/PRESCALE) mod 16,
  // tick when c mod PRESCALE = PRESCALE-1; the shadow takes v on the tick
  // where the channel phase is 15, and o shows (phase < shadow) one clock later.
  task automatic step();
    logic [7:0] e_o  [NDUT];
    logic       e_ps [NDUT];
    int         cnt;
    int         ph;
    bit         tk;
    for (int d = 0; d < NDUT; d++) begin
      cnt     = (c / pre_of(d)) % 16;
      tk      = ((c % pre_of(d)) == pre_of(d) - 1);
      e_ps[d] = tk && (cnt == 15);
      for (int i = 0; i < 8; i++) begin
        ph        = (cnt + i * off_of(d)) % 16;
        e_o[d][i] = (ph < m_sh[d][i]);
        if (tk && ph == 15) m_sh[d][i] = int'(v[d][i]);
      end
    end
    @(posedge clock);
    #1;
    c++;
    for (int d = 0; d < NDUT; d++) begin
      vectors++;
      if (o[d] !== e_o[d] || ps[d] !== e_ps[d]) begin
        miscompares++;
        $display("FAIL model dut%0d c=%0d: o=%b ps=%b expected o=%b ps=%b",
                 d, c, o[d], ps[d], e_o[d], e_ps[d]);
      end
    end
  endtask

  task automatic release_reset();
    @(negedge clock);
    reset = 1'b1;
    c = 0;
    for (int d = 0; d < NDUT; d++)
      for (int i = 0; i < 8; i++) m_sh[d][i] = 0;
  endtask

  initial begin
    bit in_win;
    bit prev;
    int hi_a;
    int hi_b;
    int rises;
    int guard;
    int fr;
    int hi;

    vectors     = 0;
    miscompares = 0;
    c           = 0;

    tab[0]  = '{0, 0, 4, 17, 4};
    tab[1]  = '{0, 1, 0, -1, 0};
    tab[2]  = '{0, 2, 15, 17, 15};
    tab[3]  = '{0, 3, 4, 17, 4};
    tab[4]  = '{1, 0, 8, 17, 8};
    tab[5]  = '{1, 1, 8, 15, 8};
    tab[6]  = '{1, 2, 8, 13, 8};
    tab[7]  = '{1, 3, 8, 11, 8};
    tab[8]  = '{1, 4, 8, 9, 8};
    tab[9]  = '{1, 5, 8, 7, 8};
    tab[10] = '{1, 6, 8, 5, 8};
    tab[11] = '{1, 7, 8, 3, 8};
    tab[12] = '{2, 0, 1, 49, 3};
    tab[13] = '{2, 7, 1, 7, 3};

    for (int d = 0; d < NDUT; d++) begin
      ps_cnt[d] = 0;
      for (int i = 0; i < 8; i++) begin
        v[d][i]          = (d == 0) ? W'(4) : ((d == 1) ? W'(8) : W'(1));
        first_rise[d][i] = -1;
        high_cnt[d][i]   = 0;
      end
    end
    for (int k = 0; k < NTAB; k++) v[tab[k].d][tab[k].ch] = W'(tab[k].duty);

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    for (int d = 0; d < NDUT; d++)
      check($sformatf("reset dut%0d {ps,o}", d), int'({ps[d], o[d]}), 0);

    // Table run: held duties from reset, measure first rise and per-period highs
    release_reset();
    for (int n = 0; n < 100; n++) begin
      step();
      for (int d = 0; d < NDUT; d++) begin
        in_win = (c >= 51) && (c < 51 + 16 * pre_of(d));
        if (in_win && ps[d]) ps_cnt[d]++;
        for (int i = 0; i < 8; i++) begin
          if (o[d][i] && first_rise[d][i] < 0) first_rise[d][i] = c;
          if (in_win && o[d][i]) high_cnt[d][i]++;
        end
      end
    end
    for (int k = 0; k < NTAB; k++) begin
      fr = first_rise[tab[k].d][tab[k].ch];
      hi = high_cnt[tab[k].d][tab[k].ch];
      check($sformatf("first rise dut%0d ch%0d", tab[k].d, tab[k].ch), fr, tab[k].first_rise);
      check($sformatf("highs/period dut%0d ch%0d", tab[k].d, tab[k].ch), hi, tab[k].high);
    end
    for (int d = 0; d < NDUT; d++)
      check($sformatf("period_start pulses dut%0d", d), ps_cnt[d], 1);

    // Mid-period duty change on dut0 ch0: 2 -> 12 while cnt=5
    v[0][0] = W'(2);
    guard = 0;
    while ((c % 16) != 0 && guard < 32) begin
      step();
      guard++;
    end
    check("align to cnt=0", c % 16, 0);
    hi_a  = 0;
    hi_b  = 0;
    rises = 0;
    prev  = o[0][0];
    for (int n = 0; n < 32; n++) begin
      step();
      if ((c % 16) == 5 && n < 16) v[0][0] = W'(12);
      if (o[0][0] && !prev) rises++;
      prev = o[0][0];
      if (n < 16) hi_a += int'(o[0][0]);
      else        hi_b += int'(o[0][0]);
    end
    check("duty change old period highs", hi_a, 2);
    check("duty change new period highs", hi_b, 12);
    check("duty change rising edges", rises, 2);

    // Randomised duty updates, checked by the model every clock
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0)
        v[$urandom_range(0, NDUT - 1)][$urandom_range(0, 7)] = W'($urandom_range(0, 15));
      step();
    end

    // Reset while dut1 ch0 is high at cnt=9
    v[1][0] = W'(12);
    repeat (40) step();
    guard = 0;
    while ((c % 16) != 9 && guard < 32) begin
      step();
      guard++;
    end
    check("pre-reset dut1 ch0 high", int'(o[1][0]), 1);
    reset = 1'b0;
    #1;
    for (int d = 0; d < NDUT; d++)
      check($sformatf("async reset dut%0d {ps,o}", d), int'({ps[d], o[d]}), 0);
    repeat (2) @(posedge clock);
    release_reset();
    hi_a = 0;
    fr   = -1;
    for (int n = 0; n < 20; n++) begin
      step();
      if (c <= 16) hi_a += int'(o[1][0]);
      if (o[1][0] && fr < 0) fr = c;
    end
    check("post-reset dut1 ch0 highs before reload", hi_a, 0);
    check("post-reset dut1 ch0 first rise", fr, 17);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
